// File: rtl/decode_queue.sv
// RV32I decode stage with an elastic FIFO of DEPTH decoded records between fetch and issue.
// Define DECODE_QUEUE_MULDIV_EN to accept the M-extension (MUL..REMU) encodings on OP.
module decode_queue #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_unit,
    output logic [2:0]               out_funct3,
    output logic                     out_alt,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [31:0]              out_imm,
    output logic [PC_W-1:0]          out_pc,
    output logic [31:0]              out_raw,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   out_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = 8 + 1 + 15 + 32 + 1 + PC_W + 32;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [7:0] U_ALU = 8'h01, U_BR = 8'h02, U_JMP = 8'h04, U_LD = 8'h08;
    localparam logic [7:0] U_ST = 8'h10, U_CSR = 8'h20, U_MD = 8'h40, U_SYS = 8'h80;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign rd_f   = in_instr[11:7];
    assign rs1_f  = in_instr[19:15];
    assign rs2_f  = in_instr[24:20];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // ---- stage p0: combinational decode of the offered word ----
    logic [7:0]         unit_p0;
    logic               alt_p0, ill_p0;
    logic [4:0]         rd_p0, rs1_p0, rs2_p0;
    logic signed [31:0] imm_p0;

    always_comb begin
        unit_p0 = '0;
        alt_p0  = 1'b0;
        rd_p0   = '0;
        rs1_p0  = '0;
        rs2_p0  = '0;
        imm_p0  = '0;
        ill_p0  = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111: begin
                unit_p0 = U_ALU; rd_p0 = rd_f; imm_p0 = imm_u;
            end
            7'b1101111: begin
                unit_p0 = U_JMP; rd_p0 = rd_f; imm_p0 = imm_j;
            end
            7'b1100111: begin
                if (f3 == 3'd0) begin
                    unit_p0 = U_JMP; rd_p0 = rd_f; rs1_p0 = rs1_f; imm_p0 = imm_i;
                end else ill_p0 = 1'b1;
            end
            7'b1100011: begin
                if (f3 != 3'd2 && f3 != 3'd3) begin
                    unit_p0 = U_BR; rs1_p0 = rs1_f; rs2_p0 = rs2_f; imm_p0 = imm_b;
                end else ill_p0 = 1'b1;
            end
            7'b0000011: begin
                if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
                    unit_p0 = U_LD; rd_p0 = rd_f; rs1_p0 = rs1_f; imm_p0 = imm_i;
                end else ill_p0 = 1'b1;
            end
            7'b0100011: begin
                if (f3 <= 3'd2) begin
                    unit_p0 = U_ST; rs1_p0 = rs1_f; rs2_p0 = rs2_f; imm_p0 = imm_s;
                end else ill_p0 = 1'b1;
            end
            7'b0010011: begin
                // shift-immediates carry funct7 in the immediate field and must be well-formed
                if ((f3 == 3'd1 && f7 != 7'b0000000) ||
                    (f3 == 3'd5 && f7 != 7'b0000000 && f7 != 7'b0100000)) begin
                    ill_p0 = 1'b1;
                end else begin
                    unit_p0 = U_ALU; rd_p0 = rd_f; rs1_p0 = rs1_f; imm_p0 = imm_i;
                    alt_p0  = (f3 == 3'd1 || f3 == 3'd5) ? in_instr[30] : 1'b0;
                end
            end
            7'b0110011: begin
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    unit_p0 = U_ALU; rd_p0 = rd_f; rs1_p0 = rs1_f; rs2_p0 = rs2_f;
                    alt_p0  = in_instr[30];
                end
`ifdef DECODE_QUEUE_MULDIV_EN
                else if (f7 == 7'b0000001) begin
                    unit_p0 = U_MD; rd_p0 = rd_f; rs1_p0 = rs1_f; rs2_p0 = rs2_f;
                end
`endif
                else ill_p0 = 1'b1;
            end
            7'b0001111: begin
                if (f3 == 3'd0 || f3 == 3'd1) unit_p0 = U_SYS;
                else ill_p0 = 1'b1;
            end
            7'b1110011: begin
                if (f3 == 3'd0) begin
                    if (in_instr == 32'h0000_0073 || in_instr == 32'h0010_0073 ||
                        in_instr == 32'h3020_0073) unit_p0 = U_SYS;
                    else ill_p0 = 1'b1;
                end else if (f3 == 3'd4) begin
                    ill_p0 = 1'b1;
                end else begin
                    unit_p0 = U_CSR; rd_p0 = rd_f;
                    if (f3[2]) imm_p0 = {27'b0, rs1_f};
                    else begin
                        rs1_p0 = rs1_f; imm_p0 = imm_i;
                    end
                end
            end
            default: ill_p0 = 1'b1;
        endcase
    end

    // ---- stage p1: queue storage and pointer control ----
    logic [REC_W-1:0] mem_p1 [DEPTH];
    logic [REC_W-1:0] head_p1;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic             ready_q, push, pop;

    assign push      = in_valid && ready_q;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != '0);
    assign in_ready  = ready_q;
    assign out_count = count;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_nxt;
            ready_q <= (count_nxt != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_p1[wr_ptr] <= {unit_p0, alt_p0, rd_p0, rs1_p0, rs2_p0, imm_p0, ill_p0, in_pc, in_instr};
    end

    assign head_p1    = out_valid ? mem_p1[rd_ptr] : '0;
    assign {out_unit, out_alt, out_rd, out_rs1, out_rs2, out_imm, out_illegal, out_pc, out_raw} = head_p1;
    assign out_funct3 = out_raw[14:12];

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: table of decoded-instruction vectors through a scoreboard,
// plus hand sequences for back-pressure, flush and mid-stream reset.
module tb_decode_queue;
    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [31:0] in_instr, out_imm, out_raw;
    logic [7:0]  out_unit;
    logic [2:0]  out_funct3;
    logic        out_alt, out_illegal;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [$clog2(DEPTH):0] out_count;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_unit(out_unit), .out_funct3(out_funct3), .out_alt(out_alt),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_pc(out_pc), .out_raw(out_raw), .out_illegal(out_illegal), .out_count(out_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  u;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] pc;
    } rec_t;

    rec_t sb[$];
    rec_t cur;
    rec_t vec[21];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   bp = 1'b0;
    logic [127:0] act;

    assign act = {4'b0, out_unit, out_funct3, out_alt, out_rd, out_rs1, out_rs2, out_imm,
                  out_illegal, out_pc, out_raw};

    function automatic rec_t mk(logic [31:0] ins, logic [7:0] u, logic [2:0] f3, logic alt,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [31:0] imm, logic ill);
        rec_t r;
        r.instr = ins; r.u = u; r.f3 = f3; r.alt = alt; r.rd = rd; r.rs1 = rs1;
        r.rs2 = rs2; r.imm = imm; r.ill = ill; r.pc = '0;
        return r;
    endfunction

    function automatic logic [127:0] pack(rec_t r);
        return {4'b0, r.u, r.f3, r.alt, r.rd, r.rs1, r.rs2, r.imm, r.ill, r.pc, r.instr};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // scoreboard: pop-compare on each consumed head, then record each accepted push
    always @(negedge clk) begin
        rec_t e;
        if (out_valid === 1'b0) chk("idle_zero", act, 128'(0));
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 128'(sb.size()), 128'(1));
                else begin
                    e = sb.pop_front();
                    chk("head", act, pack(e));
                end
            end
            if (in_valid && in_ready) sb.push_back(cur);
        end
    end

    task automatic send(input rec_t r, input logic [31:0] pc);
        bit acc;
        int g;
        acc = 1'b0;
        g = 0;
        cur = r;
        cur.pc = pc;
        in_valid = 1'b1;
        in_instr = r.instr;
        in_pc = pc;
        while (!acc && g < 100) begin
            if (bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end
        chk("send_accept", 128'(acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int g;
        g = 0;
        out_ready = 1'b1;
        while (out_count != 0 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain", 128'(out_count), 128'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;

        vec[0]  = mk(32'hFFF10093, 8'h01, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0);
        vec[1]  = mk(32'hFE208EE3, 8'h02, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
`ifdef DECODE_QUEUE_MULDIV_EN
        vec[2]  = mk(32'h022081B3, 8'h40, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
`else
        vec[2]  = mk(32'h022081B3, 8'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
`endif
        vec[3]  = mk(32'h3003D2F3, 8'h20, 3'd5, 1'b0, 5'd5, 5'd0, 5'd0, 32'h7, 1'b0);
        vec[4]  = mk(32'h407302B3, 8'h01, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0);
        vec[5]  = mk(32'h40315093, 8'h01, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'h403, 1'b0);
        vec[6]  = mk(32'h0081A203, 8'h08, 3'd2, 1'b0, 5'd4, 5'd3, 5'd0, 32'h8, 1'b0);
        vec[7]  = mk(32'hFE512E23, 8'h10, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC, 1'b0);
        vec[8]  = mk(32'h123453B7, 8'h01, 3'd5, 1'b0, 5'd7, 5'd0, 5'd0, 32'h12345000, 1'b0);
        vec[9]  = mk(32'h008000EF, 8'h04, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h8, 1'b0);
        vec[10] = mk(32'h00008067, 8'h04, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'h0, 1'b0);
        vec[11] = mk(32'h00000073, 8'h80, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        vec[12] = mk(32'hFFFFFFFF, 8'h00, 3'd7, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        vec[13] = mk(32'h40109093, 8'h00, 3'd1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        vec[14] = mk(32'h04208033, 8'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        vec[15] = mk(32'h00001117, 8'h01, 3'd1, 1'b0, 5'd2, 5'd0, 5'd0, 32'h1000, 1'b0);
        vec[16] = mk(32'h30200073, 8'h80, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        vec[17] = mk(32'h3420A373, 8'h20, 3'd2, 1'b0, 5'd6, 5'd1, 5'd0, 32'h342, 1'b0);
        vec[18] = mk(32'h0000000F, 8'h80, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        vec[19] = mk(32'h00000000, 8'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        vec[20] = mk(32'hFFF04483, 8'h08, 3'd4, 1'b0, 5'd9, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_count", 128'(out_count), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) send(vec[i], 32'h1000 + 32'(4 * i));
        wait_empty();

        bp = 1'b1;
        for (int i = 0; i < 21; i++) send(vec[i], 32'h2000 + 32'(4 * i));
        bp = 1'b0;
        wait_empty();

        // fill to DEPTH, third word must be held off until space frees up
        out_ready = 1'b0;
        send(vec[0], 32'h3000);
        send(vec[1], 32'h3004);
        chk("full_in_ready", 128'(in_ready), 128'(0));
        chk("full_count", 128'(out_count), 128'(2));
        cur = vec[3];
        cur.pc = 32'h3008;
        in_valid = 1'b1; in_instr = vec[3].instr; in_pc = 32'h3008;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_count", 128'(out_count), 128'(2));
        chk("hold_head_raw", 128'(out_raw), 128'(vec[0].instr));
        out_ready = 1'b1;
        send(vec[3], 32'h3008);
        wait_empty();

        // flush on a full queue while fetch offers a word
        out_ready = 1'b0;
        send(vec[4], 32'h4000);
        send(vec[5], 32'h4004);
        in_valid = 1'b1; in_instr = vec[6].instr; in_pc = 32'h4008;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_count", 128'(out_count), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        chk("flush_raw", 128'(out_raw), 128'(0));
        out_ready = 1'b1;
        send(vec[7], 32'h4010);
        wait_empty();

        // flush with simultaneous push and pop both discarded
        out_ready = 1'b0;
        send(vec[8], 32'h5000);
        out_ready = 1'b1; in_valid = 1'b1; in_instr = vec[9].instr; in_pc = 32'h5004;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_pp_count", 128'(out_count), 128'(0));
        chk("flush_pp_valid", 128'(out_valid), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("flush_pp_still_empty", 128'(out_count), 128'(0));

        // reset mid-stream
        out_ready = 1'b0;
        send(vec[10], 32'h6000);
        send(vec[11], 32'h6004);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_count", 128'(out_count), 128'(0));
        chk("rst_mid_in_ready", 128'(in_ready), 128'(0));
        chk("rst_mid_fields", act, 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_ready_after", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        send(vec[17], 32'h6008);
        wait_empty();

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
